// File: rtl/window_pkg.sv
// -----------------------------------------------------------------------------
// window_pkg
// Shared defaults and types for the 3x3 window generator and its line buffers.
//   DEF_DATA_W : default pixel width
//   DEF_IMG_W  : default active pixels per line
//   DEF_IMG_H  : default active lines per frame
//   DEF_COL_W  : column counter width for the default line length
//   DEF_ROW_W  : row counter width for the default frame height
//   pixel_t    : pixel of the default width
// -----------------------------------------------------------------------------
package window_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_IMG_W  = 640;
    localparam int unsigned DEF_IMG_H  = 480;
    localparam int unsigned DEF_COL_W  = $clog2(DEF_IMG_W);
    localparam int unsigned DEF_ROW_W  = $clog2(DEF_IMG_H);

    typedef logic [DEF_DATA_W-1:0] pixel_t;

endpackage

// File: rtl/line_buf.sv
// -----------------------------------------------------------------------------
// line_buf
// Single-port line memory, read-before-write. The read is combinational on the
// address, so the data returned in the accept cycle is the value stored one
// line earlier at that column; a write on the same edge replaces it.
// Contents are deliberately not reset.
// Ports:
//   clk_i   : clock, rising edge
//   wr_en_i : write strobe (one per accepted pixel)
//   addr_i  : column address, shared by read and write
//   wdata_i : value to store
//   rdata_o : value stored at addr_i before this cycle's write
// -----------------------------------------------------------------------------
module line_buf
    import window_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_IMG_W
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/window3x3_gen.sv
// -----------------------------------------------------------------------------
// window3x3_gen
// Streaming 3x3 neighbourhood generator. Accepts one raster-order pixel per
// din_valid cycle, keeps two previous lines in line buffers and presents a
// registered 3x3 window one cycle after every accept whose position (r,c) has
// r>=2 and c>=2. The window is centred on (r-1,c-1).
// Optional feature macro: WIN_POS_EN adds win_row/win_col centre coordinates.
// Ports:
//   clk             : clock, rising edge
//   rst             : asynchronous, active-low reset
//   din_valid       : pixel strobe
//   sof             : start of frame, qualified by din_valid, forces (0,0)
//   din             : pixel value
//   win1_1..win3_3  : window taps, row 1 = oldest line, column 1 = oldest pixel
//   win_row/win_col : window centre coordinates (WIN_POS_EN only)
//   win_valid       : one-cycle pulse per window
// -----------------------------------------------------------------------------
module window3x3_gen
    import window_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned IMG_W  = DEF_IMG_W,
    parameter int unsigned IMG_H  = DEF_IMG_H
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_valid,
    input  logic                     sof,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        win1_1,
    output logic [DATA_W-1:0]        win1_2,
    output logic [DATA_W-1:0]        win1_3,
    output logic [DATA_W-1:0]        win2_1,
    output logic [DATA_W-1:0]        win2_2,
    output logic [DATA_W-1:0]        win2_3,
    output logic [DATA_W-1:0]        win3_1,
    output logic [DATA_W-1:0]        win3_2,
    output logic [DATA_W-1:0]        win3_3,
`ifdef WIN_POS_EN
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
`endif
    output logic                     win_valid
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    localparam logic [COL_W-1:0] ColLast  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] RowLast  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] ColFirst = COL_W'(2);
    localparam logic [ROW_W-1:0] RowFirst = ROW_W'(2);

    // Position counters hold the raster position of the next pixel to accept.
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    // Position of the pixel presented this cycle (sof overrides the counters).
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;

    logic              accept;
    logic              frame_start;
    logic [DATA_W-1:0] lb0_rdata;
    logic [DATA_W-1:0] lb1_rdata;

    // tap_q[row][col]: row 0 = oldest line, col 0 = oldest pixel.
    logic [DATA_W-1:0] tap_q [3][3];
    logic [DATA_W-1:0] tap_d [3][3];

    logic win_valid_q, win_valid_d;

    assign accept      = din_valid;
    assign frame_start = din_valid & sof;

    // -------------------------------------------------------------------------
    // Raster position tracking
    // -------------------------------------------------------------------------
    always_comb begin
        cur_col = frame_start ? '0 : col_q;
        cur_row = frame_start ? '0 : row_q;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (cur_col == ColLast) begin
                col_d = '0;
                row_d = (cur_row == RowLast) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // -------------------------------------------------------------------------
    // Line buffers: LB0 delays by one line, LB1 by two (fed from LB0's read).
    // -------------------------------------------------------------------------
    line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_lb0 (
        .clk_i   (clk),
        .wr_en_i (accept),
        .addr_i  (cur_col),
        .wdata_i (din),
        .rdata_o (lb0_rdata)
    );

    line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_lb1 (
        .clk_i   (clk),
        .wr_en_i (accept),
        .addr_i  (cur_col),
        .wdata_i (lb0_rdata),
        .rdata_o (lb1_rdata)
    );

    // -------------------------------------------------------------------------
    // 3x3 shift register, shifts left on every accepted pixel
    // -------------------------------------------------------------------------
    always_comb begin
        tap_d = tap_q;
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                tap_d[i][0] = tap_q[i][1];
                tap_d[i][1] = tap_q[i][2];
            end
            tap_d[0][2] = lb1_rdata;
            tap_d[1][2] = lb0_rdata;
            tap_d[2][2] = din;
        end
    end

    // Columns 0-1 and rows 0-1 emit nothing, which also hides stale line
    // buffer contents after reset or a mid-frame sof.
    always_comb begin
        win_valid_d = accept && (cur_row >= RowFirst) && (cur_col >= ColFirst);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap_q       <= '{default: '0};
            win_valid_q <= 1'b0;
        end else begin
            tap_q       <= tap_d;
            win_valid_q <= win_valid_d;
        end
    end

`ifdef WIN_POS_EN
    // -------------------------------------------------------------------------
    // Centre coordinates, updated only when a window is produced
    // -------------------------------------------------------------------------
    logic [ROW_W-1:0] win_row_q, win_row_d;
    logic [COL_W-1:0] win_col_q, win_col_d;

    always_comb begin
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        if (win_valid_d) begin
            win_row_d = cur_row - 1'b1;
            win_col_d = cur_col - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_row_q <= '0;
            win_col_q <= '0;
        end else begin
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
        end
    end

    assign win_row = win_row_q;
    assign win_col = win_col_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign win1_1    = tap_q[0][0];
    assign win1_2    = tap_q[0][1];
    assign win1_3    = tap_q[0][2];
    assign win2_1    = tap_q[1][0];
    assign win2_2    = tap_q[1][1];
    assign win2_3    = tap_q[1][2];
    assign win3_1    = tap_q[2][0];
    assign win3_2    = tap_q[2][1];
    assign win3_3    = tap_q[2][2];
    assign win_valid = win_valid_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// -----------------------------------------------------------------------------
// tb_window3x3_gen
// Self-checking bench for window3x3_gen with IMG_W=8, IMG_H=6. A reference
// model stores every accepted pixel of the current frame in an image array and
// cuts the expected window straight out of it.
// -----------------------------------------------------------------------------
module tb_window3x3_gen;

    localparam int W = 8;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] win1_1, win1_2, win1_3, win2_1, win2_2, win2_3, win3_1, win3_2, win3_3;
    logic       win_valid;
`ifdef WIN_POS_EN
    logic [2:0] win_row, win_col;
`endif

    window3x3_gen #(
        .DATA_W (8),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .sof       (sof),
        .din       (din),
        .win1_1    (win1_1),
        .win1_2    (win1_2),
        .win1_3    (win1_3),
        .win2_1    (win2_1),
        .win2_2    (win2_2),
        .win2_3    (win2_3),
        .win3_1    (win3_1),
        .win3_2    (win3_2),
        .win3_3    (win3_3),
`ifdef WIN_POS_EN
        .win_row   (win_row),
        .win_col   (win_col),
`endif
        .win_valid (win_valid)
    );

    always #5 clk = ~clk;

    logic [7:0] obs [9];
    assign obs[0] = win1_1;
    assign obs[1] = win1_2;
    assign obs[2] = win1_3;
    assign obs[3] = win2_1;
    assign obs[4] = win2_2;
    assign obs[5] = win2_3;
    assign obs[6] = win3_1;
    assign obs[7] = win3_2;
    assign obs[8] = win3_3;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] img [H][W];
    int         m_row, m_col;
    logic       exp_valid;
    logic [7:0] exp_win [9];
    bit         win_known;
    int         exp_r, exp_c;

    // Observations captured by test_stream for scenario-level checks
    int         pulses;
    logic [7:0] first_win [9];
    logic [7:0] last_win [9];
    int         first_r, first_c, last_r, last_c;
    bit         r3_seen;
    logic [7:0] r3_w11, r3_w33;

    task automatic model_reset();
        m_row     = 0;
        m_col     = 0;
        exp_valid = 1'b0;
        win_known = 1'b1;
        exp_r     = 0;
        exp_c     = 0;
        for (int k = 0; k < 9; k++) exp_win[k] = 8'h00;
    endtask

    task automatic model_accept(input bit s, input logic [7:0] d, output int r, output int c);
        r = s ? 0 : m_row;
        c = s ? 0 : m_col;
        img[r][c] = d;
        exp_valid = (r >= 2) && (c >= 2);
        if (exp_valid) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    exp_win[i*3+j] = img[r-2+i][c-2+j];
            exp_r     = r - 1;
            exp_c     = c - 1;
            win_known = 1'b1;
        end else begin
            win_known = 1'b0;
        end
        m_row = r;
        m_col = c + 1;
        if (m_col == W) begin
            m_col = 0;
            m_row = (r + 1) % H;
        end
    endtask

    // Streams n accepted pixels with gap_pct% idle cycles, checking every cycle.
    task automatic test_stream(input int n, input int gap_pct, input bit sof_first,
                               input bit rand_data, input string tag);
        bit         v, s;
        logic [7:0] d;
        int         r, c, pr, pc;
        int         k;
        pulses  = 0;
        r3_seen = 1'b0;
        k       = 0;
        while (k < n) begin
            v = ($urandom_range(99) >= gap_pct);
            s = 1'b0;
            d = 8'h00;
            if (v) begin
                s  = sof_first && (k == 0);
                pr = s ? 0 : m_row;
                pc = s ? 0 : m_col;
                d  = rand_data ? 8'($urandom) : {pr[3:0], pc[3:0]};
            end
            din_valid = v;
            sof       = s;
            din       = d;
            @(posedge clk);
            #1;
            r = -1;
            c = -1;
            if (v) begin
                model_accept(s, d, r, c);
                k++;
            end else begin
                exp_valid = 1'b0;
            end
            checks++;
            if (win_valid !== exp_valid) begin
                errors++;
                $display("FAIL %s win_valid at pos (%0d,%0d): got %b want %b",
                         tag, r, c, win_valid, exp_valid);
            end
            if (win_known) begin
                for (int q = 0; q < 9; q++) begin
                    checks++;
                    if (obs[q] !== exp_win[q]) begin
                        errors++;
                        $display("FAIL %s tap win%0d_%0d pos (%0d,%0d): got %h want %h",
                                 tag, q / 3 + 1, q % 3 + 1, r, c, obs[q], exp_win[q]);
                    end
                end
            end
`ifdef WIN_POS_EN
            checks++;
            if (win_row !== 3'(exp_r) || win_col !== 3'(exp_c)) begin
                errors++;
                $display("FAIL %s win_row/win_col: got %0d/%0d want %0d/%0d",
                         tag, win_row, win_col, exp_r, exp_c);
            end
`endif
            if (win_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) first_win = obs;
                last_win = obs;
`ifdef WIN_POS_EN
                if (pulses == 1) begin
                    first_r = int'(win_row);
                    first_c = int'(win_col);
                end
                last_r = int'(win_row);
                last_c = int'(win_col);
`endif
                if (r == 3 && c == 2) begin
                    r3_seen = 1'b1;
                    r3_w11  = win1_1;
                    r3_w33  = win3_3;
                end
            end
        end
        din_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        din_valid = 1'b0;
        #12;
        checks++;
        if (win_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset win_valid: got %b want 0", win_valid);
        end
        for (int q = 0; q < 9; q++) begin
            checks++;
            if (obs[q] !== 8'h00) begin
                errors++;
                $display("FAIL reset tap %0d: got %h want 00", q, obs[q]);
            end
        end
`ifdef WIN_POS_EN
        checks++;
        if (win_row !== 3'd0 || win_col !== 3'd0) begin
            errors++;
            $display("FAIL reset win_row/win_col: got %0d/%0d want 0/0", win_row, win_col);
        end
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic check_frame_shape(input string tag);
        checks++;
        if (pulses != 24) begin
            errors++;
            $display("FAIL %s pulse count: got %0d want 24", tag, pulses);
        end
        checks++;
        if (first_win[0] !== 8'h00 || first_win[4] !== 8'h11 || first_win[8] !== 8'h22) begin
            errors++;
            $display("FAIL %s first window 1_1/2_2/3_3: got %h/%h/%h want 00/11/22",
                     tag, first_win[0], first_win[4], first_win[8]);
        end
        checks++;
        if (last_win[4] !== 8'h46) begin
            errors++;
            $display("FAIL %s last window 2_2: got %h want 46", tag, last_win[4]);
        end
`ifdef WIN_POS_EN
        checks++;
        if (first_r != 1 || first_c != 1 || last_r != 4 || last_c != 6) begin
            errors++;
            $display("FAIL %s centre first/last: got (%0d,%0d)/(%0d,%0d) want (1,1)/(4,6)",
                     tag, first_r, first_c, last_r, last_c);
        end
`endif
    endtask

    task automatic test_full_frame();
        test_stream(W * H, 0, 1'b1, 1'b0, "full");
        check_frame_shape("full");
        checks++;
        if (!r3_seen || r3_w11 !== 8'h10 || r3_w33 !== 8'h32) begin
            errors++;
            $display("FAIL row3 first window: seen %b got %h/%h want 10/32",
                     r3_seen, r3_w11, r3_w33);
        end
    endtask

    task automatic test_random_gaps();
        test_stream(W * H, 50, 1'b1, 1'b0, "gaps");
        check_frame_shape("gaps");
    endtask

    task automatic test_mid_sof();
        test_stream(3 * W + 4, 0, 1'b1, 1'b0, "partial");
        test_stream(W * H, 30, 1'b1, 1'b0, "after_sof");
        check_frame_shape("after_sof");
    endtask

    task automatic test_async_reset();
        test_stream(4 * W + 4, 0, 1'b1, 1'b0, "pre_rst");
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (win_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_rst win_valid: got %b want 0", win_valid);
        end
        for (int q = 0; q < 9; q++) begin
            checks++;
            if (obs[q] !== 8'h00) begin
                errors++;
                $display("FAIL async_rst tap %0d: got %h want 00", q, obs[q]);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        test_stream(W * H, 25, 1'b0, 1'b1, "post_rst");
        checks++;
        if (pulses != 24) begin
            errors++;
            $display("FAIL post_rst pulse count: got %0d want 24", pulses);
        end
    endtask

    task automatic test_back_to_back();
        test_stream(2 * W * H, 20, 1'b0, 1'b1, "b2b");
        checks++;
        if (pulses != 48) begin
            errors++;
            $display("FAIL b2b pulse count: got %0d want 48", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_random_gaps();
        test_mid_sof();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
